seg_scan_driver: RTL and testbench

//  Time-multiplexed scan driver for a bank of common-anode 7-segment digits.

---
 rtl/seg_scan_driver.sv | 168 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed scan driver for a bank of common-anode 7-segment digits.
//   Segment patterns are double-buffered. A load strobe fills the pending
//   buffer. The active buffer is refreshed only at a frame boundary or when
//   en rises, so the display never tears. A dark gap before each digit
//   suppresses ghosting.
//
//   state | meaning
//   BLANK | all digits dark, counting out the gap before digit_idx
//   ON    | digit digit_idx lit with its active pattern
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   en         in   scan enable, 0 = display dark
//   load       in   1-cycle strobe, captures seg_in into the pending buffer
//   seg_in     in   8*NDIG packed patterns, digit k = seg_in[8k+7:8k], active-low
//   seg_out    out  segment drive, active-low
//   an_n       out  digit enables, active-low, at most one bit low
//   digit_idx  out  digit currently selected
//   frame_done out  high during the final ON cycle of the last digit
//   pending    out  loaded data not yet committed to the display
module seg_scan_driver #(
  parameter int NDIG      = 8,
  parameter int ON_CYC    = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [8*NDIG-1:0]       seg_in,
  output logic [7:0]              seg_out,
  output logic [NDIG-1:0]         an_n,
  output logic [$clog2(NDIG)-1:0] digit_idx,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int IW   = $clog2(NDIG);
  localparam int CMAX = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  // Phase timers count down to zero, so each phase is entered with length-1.
  localparam logic [CW-1:0] ON_LD  = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] BLK_LD = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IW-1:0] LAST   = IW'(NDIG - 1);

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [IW-1:0]       idx_nxt;
  logic                en_q;
  logic                commit;
  logic [8*NDIG-1:0]   pend_buf, pend_nxt;
  logic [8*NDIG-1:0]   act_buf, act_nxt;
  logic                pending_nxt;
  logic [7:0]          seg_nxt;
  logic [NDIG-1:0]     an_nxt;
  logic                frame_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      digit_idx  <= '0;
      en_q       <= 1'b0;
      pend_buf   <= '1;
      act_buf    <= '1;
      pending    <= 1'b0;
      seg_out    <= 8'hFF;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      digit_idx  <= idx_nxt;
      en_q       <= en;
      pend_buf   <= pend_nxt;
      act_buf    <= act_nxt;
      pending    <= pending_nxt;
      seg_out    <= seg_nxt;
      an_n       <= an_nxt;
      frame_done <= frame_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = digit_idx;
    commit      = 1'b0;
    act_nxt     = act_buf;
    pend_nxt    = pend_buf;
    pending_nxt = pending;
    seg_nxt     = 8'hFF;
    an_nxt      = '1;
    frame_nxt   = 1'b0;

    if (!en) begin
      state_nxt = ST_BLANK;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else if (!en_q) begin
      // Restart: fresh data, then the gap ahead of digit 0.
      commit  = 1'b1;
      idx_nxt = '0;
      if (BLANK_CYC == 0) begin
        state_nxt = ST_ON;
        cnt_nxt   = ON_LD;
      end else begin
        state_nxt = ST_BLANK;
        cnt_nxt   = BLK_LD;
      end
    end else begin
      case (state)
        ST_BLANK: begin
          if (cnt == '0) begin
            state_nxt = ST_ON;
            cnt_nxt   = ON_LD;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        default: begin
          if (cnt == '0) begin
            if (digit_idx == LAST) begin
              idx_nxt = '0;
              commit  = 1'b1;
            end else begin
              idx_nxt = digit_idx + 1'b1;
            end
            if (BLANK_CYC == 0) begin
              state_nxt = ST_ON;
              cnt_nxt   = ON_LD;
            end else begin
              state_nxt = ST_BLANK;
              cnt_nxt   = BLK_LD;
            end
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
      endcase
    end

    // Commit takes pend_buf as it was before this cycle's load, so a load on
    // a commit cycle waits for the following boundary.
    if (commit) begin
      act_nxt     = pend_buf;
      pending_nxt = 1'b0;
    end
    if (load) begin
      pend_nxt    = seg_in;
      pending_nxt = 1'b1;
    end

    // Outputs are driven from next-state values so seg_out and an_n always
    // change together on the same edge.
    if (state_nxt == ST_ON) begin
      an_nxt[idx_nxt] = 1'b0;
      seg_nxt         = act_nxt[{idx_nxt, 3'b000} +: 8];
      frame_nxt       = (idx_nxt == LAST) && (cnt_nxt == '0);
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int ND  = 4;
  localparam int ONC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [31:0] seg_in = '0;

  logic [7:0]  seg_o [2];
  logic [3:0]  an_o  [2];
  logic [1:0]  idx_o [2];
  logic        fd_o  [2];
  logic        pend_o[2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.NDIG(ND), .ON_CYC(ONC), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .seg_in(seg_in),
    .seg_out(seg_o[0]), .an_n(an_o[0]), .digit_idx(idx_o[0]),
    .frame_done(fd_o[0]), .pending(pend_o[0])
  );

  seg_scan_driver #(.NDIG(ND), .ON_CYC(ONC), .BLANK_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .seg_in(seg_in),
    .seg_out(seg_o[1]), .an_n(an_o[1]), .digit_idx(idx_o[1]),
    .frame_done(fd_o[1]), .pending(pend_o[1])
  );

  // Reference model: time since the last enable restart, plus buffer contents.
  int          m_t;
  logic        m_enp;
  logic [31:0] m_act [2];
  logic [31:0] m_pend[2];
  logic        m_pending[2];

  function automatic int blank_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int period_of(input int k);
    return ND * (ONC + blank_of(k));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t   = 0;
    m_enp = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_act[k]     = 32'hFFFF_FFFF;
      m_pend[k]    = 32'hFFFF_FFFF;
      m_pending[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic e, input logic l, input logic [31:0] d);
    logic cm[2];
    for (int k = 0; k < 2; k++) cm[k] = 1'b0;
    if (e) begin
      if (!m_enp) begin
        cm[0] = 1'b1;
        cm[1] = 1'b1;
        m_t   = 0;
      end else begin
        for (int k = 0; k < 2; k++)
          if (m_t % period_of(k) == period_of(k) - 1) cm[k] = 1'b1;
        m_t++;
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (cm[k]) begin
        m_act[k]     = m_pend[k];
        m_pending[k] = 1'b0;
      end
      if (l) begin
        m_pend[k]    = d;
        m_pending[k] = 1'b1;
      end
    end
    m_enp = e;
  endtask

  function automatic logic exp_fd(input int k);
    return m_enp && (m_t % period_of(k) == period_of(k) - 1);
  endfunction

  function automatic int exp_digit(input int k);
    return (m_t % period_of(k)) / (ONC + blank_of(k));
  endfunction

  function automatic logic exp_lit(input int k);
    return m_enp && ((m_t % period_of(k)) % (ONC + blank_of(k)) >= blank_of(k));
  endfunction

  task automatic compare();
    int          d;
    logic        lit;
    logic [31:0] e_an, e_seg, e_idx;
    for (int k = 0; k < 2; k++) begin
      d     = exp_digit(k);
      lit   = exp_lit(k);
      e_an  = lit ? (32'hF & ~(32'h1 << d)) : 32'hF;
      e_seg = lit ? ((m_act[k] >> (8 * d)) & 32'hFF) : 32'hFF;
      e_idx = m_enp ? 32'(d) : 32'h0;
      chk($sformatf("an_n[i%0d]", k), 32'(an_o[k]), e_an);
      chk($sformatf("seg_out[i%0d]", k), 32'(seg_o[k]), e_seg);
      chk($sformatf("digit_idx[i%0d]", k), 32'(idx_o[k]), e_idx);
      chk($sformatf("frame_done[i%0d]", k), 32'(fd_o[k]), 32'(exp_fd(k)));
      chk($sformatf("pending[i%0d]", k), 32'(pend_o[k]), 32'(m_pending[k]));
    end
  endtask

  task automatic step(input logic e, input logic l, input logic [31:0] d);
    @(negedge clk);
    en     = e;
    load   = l;
    seg_in = d;
    @(posedge clk);
    model_edge(e, l, d);
    #1;
    compare();
  endtask

  task automatic check_reset_vals(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_seg"}, 32'(seg_o[k]), 32'hFF);
      chk({tag, "_an"}, 32'(an_o[k]), 32'hF);
      chk({tag, "_idx"}, 32'(idx_o[k]), 32'h0);
      chk({tag, "_fd"}, 32'(fd_o[k]), 32'h0);
      chk({tag, "_pend"}, 32'(pend_o[k]), 32'h0);
    end
  endtask

  initial begin
    logic found;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic pattern, load together with enable.
    step(1'b1, 1'b1, 32'h80F9A4C0);
    repeat (60) step(1'b1, 1'b0, 32'h0);

    // Load mid-frame.
    repeat (5) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, $urandom);
    repeat (40) step(1'b1, 1'b0, 32'h0);

    // Load during the frame_done cycle of the gapped instance.
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (exp_fd(0)) found = 1'b1;
      else step(1'b1, 1'b0, 32'h0);
    end
    chk("fd_reached", 32'(found), 32'h1);
    step(1'b1, 1'b1, $urandom);
    repeat (60) step(1'b1, 1'b0, 32'h0);

    // Drop enable while digit 2 is lit.
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (exp_lit(0) && exp_digit(0) == 2) found = 1'b1;
      else step(1'b1, 1'b0, 32'h0);
    end
    chk("dig2_reached", 32'(found), 32'h1);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, $urandom);
    step(1'b0, 1'b0, 32'h0);
    repeat (40) step(1'b1, 1'b0, 32'h0);

    // Asynchronous reset while a digit is lit.
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (exp_lit(0)) found = 1'b1;
      else step(1'b1, 1'b0, 32'h0);
    end
    chk("on_reached", 32'(found), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, $urandom);
    repeat (50) step(1'b1, 1'b0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 800; i++)
      step(logic'($urandom_range(0, 39) != 0), logic'($urandom_range(0, 7) == 0), $urandom);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
